xadc_drp_scheduler: RTL and testbench
=====================================

# xadc_drp_scheduler

Sequences DRP reads from the `xadc_wiz_0` instance that samples the two motor current-sense channels (VAUX6, VAUX14). On each end-of-conversion it reads the converted channel's result register and routes the 12-bit result to a per-channel output. A bad read times out and is reported rather than hanging the bus. Per-channel debounced overcurrent flags with hysteresis feed the motor-enable logic, in place of the free-running address toggling and fixed-interval sampling.

## Interface
- `CH_A_ADDR`, 7'h16: DRP address of channel A (VAUX6).
- `CH_B_ADDR`, 7'h1E: DRP address of channel B (VAUX14).
- `DRDY_TIMEOUT`, 64: cycles to wait for `drdy_in` after `den_out`.
- `OC_HI`, 12'd3800: trip threshold (inclusive).
- `OC_LO`, 12'd3500: release threshold (inclusive).
- `TRIP_COUNT`, 4: consecutive qualifying samples needed to set or clear a flag.
- `clk` in 1: system clock, also the XADC `dclk_in`.
- `rst_n` in 1: synchronous, active-low reset.
- `eoc_in` in 1: XADC `eoc_out`.
- `channel_in` in 5: XADC `channel_out`.
- `drdy_in` in 1: XADC `drdy_out`.
- `do_in` in 16: XADC `do_out`.
- `den_out` out 1: DRP enable, one-cycle pulse.
- `daddr_out` out 7: DRP address, held from the `den_out` cycle until the read completes.
- `dwe_out` out 1: tied 0. The block only reads.
- `sample_a`, `sample_b` out 12: last good result per channel.
- `valid_a`, `valid_b` out 1: one-cycle pulse when the matching sample updates.
- `oc_a`, `oc_b` out 1: debounced overcurrent flags.
- `err_timeout` out 1: one-cycle pulse when a read is aborted.

## Operation
- FSM states: IDLE, REQ, WAIT, CAPT.
- IDLE:
  - Pending flag set, or `eoc_in`=1 with `{2'b00,channel_in}` equal to CH_A_ADDR or CH_B_ADDR: latch the address, go to REQ.
  - Any other channel: ignored.
- REQ: `den_out`=1 for exactly one cycle with the latched address, clear the timeout counter, go to WAIT.
- WAIT:
  - `drdy_in`=1: register `do_in[15:4]`, go to CAPT.
  - Counter reaches DRDY_TIMEOUT-1 with no `drdy_in`: pulse `err_timeout`, leave samples unchanged, go to IDLE.
- CAPT: write the sample to the matching channel, pulse its `valid_*`, step that channel's overcurrent detector, go to IDLE.
- `eoc_in` for a configured channel outside IDLE:
  - Stored in a one-deep pending slot (address plus flag).
  - A later eoc overwrites an earlier pending one; the newest wins and no count is kept.
  - Pending is consumed on the next IDLE cycle.
- `eoc_in` and `drdy_in` in the same WAIT cycle: capture proceeds and the eoc goes to pending.
- Overcurrent detector, one per channel, counter of width clog2(TRIP_COUNT+1):
  - Flag 0: sample ≥ OC_HI increments the counter, otherwise the counter clears. Counter reaching TRIP_COUNT sets the flag and clears the counter.
  - Flag 1: sample ≤ OC_LO increments the counter, otherwise the counter clears. Counter reaching TRIP_COUNT clears the flag and the counter.
- Reset values, all outputs and state:
  - FSM IDLE, pending cleared, counters 0.
  - `den_out`=0, `daddr_out`=CH_A_ADDR, `dwe_out`=0.
  - Samples 0, valids 0, `oc_*`=0, `err_timeout`=0.
- Reset mid-read: abandon the read immediately. A `drdy_in` arriving after reset is ignored because the FSM is in IDLE.

## Timing
- eoc seen in IDLE at cycle n:
  - `den_out` high at n+1.
  - Earliest capture at n+2, if `drdy_in` is high then.
  - `sample_*`/`valid_*` update at the capture cycle +1.
- `oc_*` changes in the same cycle as the `valid_*` pulse of the qualifying sample.
- Back-to-back: after CAPT, a pending request reaches REQ after one IDLE cycle. Minimum 4 cycles per read.
- Timeout: `err_timeout` pulses DRDY_TIMEOUT cycles after `den_out`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `xadc_ctrl_pkg` holds:
  - FSM state enum.
  - Default channel addresses.
  - Sample width constant (12).
  - DRP address width constant (7).
- Sub-module `oc_detector` (params OC_HI, OC_LO, TRIP_COUNT), instantiated once per channel, stepped by its channel's capture strobe.

## Test plan
- Single read:
  - Stimulus: eoc with channel 0x16; `drdy_in` 3 cycles after `den_out` with `do_in`=16'hABC0.
  - Required: `den_out` one cycle with `daddr_out`=7'h16; `sample_a`=12'hABC; one `valid_a` pulse; `sample_b` unchanged.
- Foreign channel:
  - Stimulus: eoc with channel 0x03.
  - Required: no `den_out`; all outputs unchanged.
- Pending overwrite:
  - Stimulus: during WAIT on ch A, eoc for 0x16 and then for 0x1E.
  - Required: after CAPT exactly one further read, to 7'h1E.
- Timeout:
  - Stimulus: `drdy_in` never asserted.
  - Required: `err_timeout` exactly 64 cycles after `den_out`; FSM back in IDLE; next eoc is serviced normally.
- Hysteresis:
  - Stimulus: ch B samples 3800, 3900, 3801, 3700, then 4×3800, then 3×3400, 3600, 4×3500.
  - Required: `oc_b` rises only at the 4th consecutive ≥3800 sample and falls only at the 4th consecutive ≤3500 sample.
- Reset in WAIT:
  - Stimulus: `rst_n`=0 for 1 cycle, then a stray `drdy_in` with `do_in`=16'hFFF0.
  - Required: all outputs at reset values; `sample_*` stays 0.

Source files
------------

// File: rtl/xadc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xadc_ctrl_pkg
//  Purpose  : Shared types and constants for the XADC DRP read scheduler.
//             FSM state encoding, default channel DRP addresses, sample and
//             DRP address widths.
//  Revision : 1.0  initial release
// ============================================================================
package xadc_ctrl_pkg;

  localparam int unsigned SAMPLE_W   = 12;
  localparam int unsigned DRP_ADDR_W = 7;

  // VAUX6 and VAUX14 result registers.
  localparam logic [DRP_ADDR_W-1:0] DEF_CH_A_ADDR = 7'h16;
  localparam logic [DRP_ADDR_W-1:0] DEF_CH_B_ADDR = 7'h1E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAPT = 2'd3
  } drp_state_e;

endpackage : xadc_ctrl_pkg
`default_nettype wire

// File: rtl/xadc_drp_scheduler_oc_detector.sv
`default_nettype none
// ============================================================================
//  Module   : oc_detector
//  Purpose  : Debounced overcurrent flag with hysteresis for one channel.
//             Stepped once per new sample. While clear, TRIP_COUNT
//             consecutive samples >= OC_HI set the flag; while set,
//             TRIP_COUNT consecutive samples <= OC_LO clear it.
//  Ports    : clk, rst_n     clock, synchronous active-low reset
//             step_in        1 = sample_in is a new sample
//             sample_in      12-bit converted result
//             oc_out         registered overcurrent flag
//  Revision : 1.0  initial release
// ============================================================================
module oc_detector
  import xadc_ctrl_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] OC_HI      = 12'd3800,
  parameter logic [SAMPLE_W-1:0] OC_LO      = 12'd3500,
  parameter int unsigned         TRIP_COUNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                oc_out
);

  localparam int unsigned CNT_W = $clog2(TRIP_COUNT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             qualify;

  always_comb begin
    // Which threshold counts depends on the current flag: this is the hysteresis.
    qualify = flag_q ? (sample_in <= OC_LO) : (sample_in >= OC_HI);
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    if (step_in) begin
      if (!qualify) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(TRIP_COUNT - 1)) begin
        // This sample is the TRIP_COUNT-th in a row.
        flag_d = ~flag_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign oc_out = flag_q;

endmodule : oc_detector
`default_nettype wire

// File: rtl/xadc_drp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : xadc_drp_scheduler
//  Purpose  : Issues one DRP read per XADC end-of-conversion for the two
//             motor current-sense channels, routes the 12-bit result to a
//             per-channel output, aborts reads whose drdy never arrives, and
//             derives debounced overcurrent flags.
//  Ports    : clk, rst_n              clock (= dclk), sync active-low reset
//             eoc_in, channel_in      XADC end-of-conversion and channel
//             drdy_in, do_in          DRP read handshake and data
//             den_out, daddr_out      DRP enable pulse and held address
//             dwe_out                 always 0 (read only)
//             sample_a/b, valid_a/b   per-channel result and update pulse
//             oc_a/b                  debounced overcurrent flags
//             err_timeout             pulse when a read is aborted
//  Revision : 1.0  initial release
// ============================================================================
module xadc_drp_scheduler
  import xadc_ctrl_pkg::*;
#(
  parameter logic [DRP_ADDR_W-1:0] CH_A_ADDR    = DEF_CH_A_ADDR,
  parameter logic [DRP_ADDR_W-1:0] CH_B_ADDR    = DEF_CH_B_ADDR,
  parameter int unsigned           DRDY_TIMEOUT = 64,
  parameter logic [SAMPLE_W-1:0]   OC_HI        = 12'd3800,
  parameter logic [SAMPLE_W-1:0]   OC_LO        = 12'd3500,
  parameter int unsigned           TRIP_COUNT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  eoc_in,
  input  logic [4:0]            channel_in,
  input  logic                  drdy_in,
  input  logic [15:0]           do_in,
  output logic                  den_out,
  output logic [DRP_ADDR_W-1:0] daddr_out,
  output logic                  dwe_out,
  output logic [SAMPLE_W-1:0]   sample_a,
  output logic [SAMPLE_W-1:0]   sample_b,
  output logic                  valid_a,
  output logic                  valid_b,
  output logic                  oc_a,
  output logic                  oc_b,
  output logic                  err_timeout
);

  localparam int unsigned TMO_W = $clog2(DRDY_TIMEOUT);

  drp_state_e            state_q, state_d;
  logic [DRP_ADDR_W-1:0] addr_q, addr_d;
  logic                  pend_q, pend_d;
  logic [DRP_ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  den_q, den_d;
  logic                  err_q, err_d;
  logic                  valid_a_q, valid_a_d;
  logic                  valid_b_q, valid_b_d;
  logic [SAMPLE_W-1:0]   sample_a_q, sample_a_d;
  logic [SAMPLE_W-1:0]   sample_b_q, sample_b_d;

  logic [DRP_ADDR_W-1:0] eoc_addr;
  logic                  eoc_cfg;
  logic                  unused_do_lsbs;

  assign eoc_addr       = {2'b00, channel_in};
  assign eoc_cfg        = eoc_in && ((eoc_addr == CH_A_ADDR) || (eoc_addr == CH_B_ADDR));
  // The XADC result is left-justified; the low nibble carries no data.
  assign unused_do_lsbs = ^do_in[3:0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    tmo_cnt_d   = tmo_cnt_q;
    sample_a_d  = sample_a_q;
    sample_b_d  = sample_b_q;
    den_d       = 1'b0;
    err_d       = 1'b0;
    valid_a_d   = 1'b0;
    valid_b_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          addr_d    = pend_addr_q;
          pend_d    = 1'b0;
          state_d   = ST_REQ;
          den_d     = 1'b1;
          tmo_cnt_d = '0;
        end else if (eoc_cfg) begin
          addr_d    = eoc_addr;
          state_d   = ST_REQ;
          den_d     = 1'b1;
          tmo_cnt_d = '0;
        end
      end
      ST_REQ: begin
        // The timeout count runs from the den cycle so the abort lands
        // exactly DRDY_TIMEOUT cycles after den_out.
        state_d   = ST_WAIT;
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
      ST_WAIT: begin
        if (drdy_in) begin
          // Outputs are written on this edge so they appear one cycle after
          // drdy; CAPT is the turnaround cycle back to IDLE.
          state_d = ST_CAPT;
          if (addr_q == CH_A_ADDR) begin
            sample_a_d = do_in[15:4];
            valid_a_d  = 1'b1;
          end else begin
            sample_b_d = do_in[15:4];
            valid_b_d  = 1'b1;
          end
        end else if (tmo_cnt_q == TMO_W'(DRDY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_CAPT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A configured eoc that cannot start a read now is parked; the newest
    // one wins. This includes IDLE while a pending read is being launched.
    if (eoc_cfg && ((state_q != ST_IDLE) || pend_q)) begin
      pend_d      = 1'b1;
      pend_addr_d = eoc_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= CH_A_ADDR;
      pend_q      <= 1'b0;
      pend_addr_q <= CH_A_ADDR;
      tmo_cnt_q   <= '0;
      den_q       <= 1'b0;
      err_q       <= 1'b0;
      valid_a_q   <= 1'b0;
      valid_b_q   <= 1'b0;
      sample_a_q  <= '0;
      sample_b_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      tmo_cnt_q   <= tmo_cnt_d;
      den_q       <= den_d;
      err_q       <= err_d;
      valid_a_q   <= valid_a_d;
      valid_b_q   <= valid_b_d;
      sample_a_q  <= sample_a_d;
      sample_b_q  <= sample_b_d;
    end
  end

  // Detectors step on the same edge that loads the sample, so oc_* moves
  // together with the valid_* pulse.
  oc_detector #(
    .OC_HI      (OC_HI),
    .OC_LO      (OC_LO),
    .TRIP_COUNT (TRIP_COUNT)
  ) u_oc_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_in   (valid_a_d),
    .sample_in (do_in[15:4]),
    .oc_out    (oc_a)
  );

  oc_detector #(
    .OC_HI      (OC_HI),
    .OC_LO      (OC_LO),
    .TRIP_COUNT (TRIP_COUNT)
  ) u_oc_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_in   (valid_b_d),
    .sample_in (do_in[15:4]),
    .oc_out    (oc_b)
  );

  assign den_out     = den_q;
  assign daddr_out   = addr_q;
  assign dwe_out     = 1'b0;
  assign sample_a    = sample_a_q;
  assign sample_b    = sample_b_q;
  assign valid_a     = valid_a_q;
  assign valid_b     = valid_b_q;
  assign err_timeout = err_q;

endmodule : xadc_drp_scheduler
`default_nettype wire

// File: tb/tb_xadc_drp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xadc_drp_scheduler
//  Purpose  : Self-checking bench for xadc_drp_scheduler. A transaction-level
//             model predicts every output each cycle; directed sequences pin
//             the model with literal expectations, then random traffic runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xadc_drp_scheduler;

  localparam int TMO  = 64;
  localparam int TRIP = 4;
  localparam logic [11:0] HI = 12'd3800;
  localparam logic [11:0] LO = 12'd3500;

  logic        clk = 1'b0;
  logic        rst_n, eoc_in, drdy_in;
  logic [4:0]  channel_in;
  logic [15:0] do_in;
  logic        den_out, dwe_out, valid_a, valid_b, oc_a, oc_b, err_timeout;
  logic [6:0]  daddr_out;
  logic [11:0] sample_a, sample_b;

  xadc_drp_scheduler dut (
    .clk(clk), .rst_n(rst_n), .eoc_in(eoc_in), .channel_in(channel_in),
    .drdy_in(drdy_in), .do_in(do_in), .den_out(den_out), .daddr_out(daddr_out),
    .dwe_out(dwe_out), .sample_a(sample_a), .sample_b(sample_b),
    .valid_a(valid_a), .valid_b(valid_b), .oc_a(oc_a), .oc_b(oc_b),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode 0: no read in flight; 1: den issued, age = cycles since den;
  // 2: result delivered, one turnaround cycle before accepting work.
  bit          m_den, m_va, m_vb, m_oca, m_ocb, m_err;
  logic [6:0]  m_daddr;
  logic [11:0] m_sa, m_sb;
  int          m_mode, m_age;
  bit          m_pend;
  logic [6:0]  m_pend_addr;
  logic [11:0] hist_a[$];
  logic [11:0] hist_b[$];

  // True when the last TRIP samples since the previous flag change all
  // qualify against the threshold that applies to the current flag.
  function automatic bit tripped(input logic [11:0] h[$], input bit flag);
    if (h.size() < TRIP) return 1'b0;
    for (int i = h.size() - TRIP; i < h.size(); i++) begin
      if (flag ? (h[i] > LO) : (h[i] < HI)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_start(input logic [6:0] a);
    m_den   = 1'b1;
    m_daddr = a;
    m_mode  = 1;
    m_age   = 0;
  endtask

  task automatic model_step();
    logic [6:0]  ch7;
    logic [11:0] s;
    bit          cfg, park;
    if (!rst_n) begin
      m_den = 0; m_va = 0; m_vb = 0; m_oca = 0; m_ocb = 0; m_err = 0;
      m_daddr = 7'h16; m_sa = '0; m_sb = '0;
      m_mode = 0; m_age = 0; m_pend = 0; m_pend_addr = 7'h16;
      hist_a.delete(); hist_b.delete();
      return;
    end
    ch7  = {2'b00, channel_in};
    cfg  = eoc_in && (ch7 == 7'h16 || ch7 == 7'h1E);
    park = 1'b0;
    m_den = 0; m_va = 0; m_vb = 0; m_err = 0;
    if (m_mode == 0) begin
      if (m_pend) begin
        model_start(m_pend_addr);
        m_pend = 0;
        park = cfg;
      end else if (cfg) begin
        model_start(ch7);
      end
    end else if (m_mode == 1) begin
      park = cfg;
      if (m_age >= 1 && drdy_in) begin
        s = do_in[15:4];
        if (m_daddr == 7'h16) begin
          m_sa = s; m_va = 1;
          hist_a.push_back(s);
          if (tripped(hist_a, m_oca)) begin m_oca = !m_oca; hist_a.delete(); end
          if (hist_a.size() > TRIP) void'(hist_a.pop_front());
        end else begin
          m_sb = s; m_vb = 1;
          hist_b.push_back(s);
          if (tripped(hist_b, m_ocb)) begin m_ocb = !m_ocb; hist_b.delete(); end
          if (hist_b.size() > TRIP) void'(hist_b.pop_front());
        end
        m_mode = 2;
      end else if (m_age == TMO - 1) begin
        m_err  = 1;
        m_mode = 0;
      end else begin
        m_age++;
      end
    end else begin
      park   = cfg;
      m_mode = 0;
    end
    if (park) begin
      m_pend = 1;
      m_pend_addr = ch7;
    end
  endtask

  task automatic compare_all();
    chk("den_out",     32'(den_out),     32'(m_den));
    chk("daddr_out",   32'(daddr_out),   32'(m_daddr));
    chk("dwe_out",     32'(dwe_out),     32'd0);
    chk("sample_a",    32'(sample_a),    32'(m_sa));
    chk("sample_b",    32'(sample_b),    32'(m_sb));
    chk("valid_a",     32'(valid_a),     32'(m_va));
    chk("valid_b",     32'(valid_b),     32'(m_vb));
    chk("oc_a",        32'(oc_a),        32'(m_oca));
    chk("oc_b",        32'(oc_b),        32'(m_ocb));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
  endtask

  // One clock: model consumes the inputs the DUT samples on this edge,
  // then outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic read_b(input logic [11:0] v, output logic oc);
    channel_in = 5'h1E; eoc_in = 1'b1;
    tick();
    eoc_in = 1'b0;
    tick();
    drdy_in = 1'b1; do_in = {v, 4'h0};
    tick();
    drdy_in = 1'b0;
    oc = oc_b;
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          k, nden, nvb;
    logic [6:0]  den_addr;
    logic        oc;
    logic [11:0] hv[16];
    logic [15:0] exp_oc;
    int          drdy_div;

    rst_n = 1'b0; eoc_in = 1'b0; drdy_in = 1'b0; channel_in = 5'h0; do_in = 16'h0;
    tick(); tick();
    chk("reset_daddr", 32'(daddr_out), 32'h16);
    chk("reset_den",   32'(den_out),   32'h0);
    chk("reset_samp",  32'(sample_a),  32'h0);
    rst_n = 1'b1;
    tick();

    // Single read on channel A, drdy three cycles after den.
    channel_in = 5'h16; eoc_in = 1'b1;
    tick();
    eoc_in = 1'b0;
    chk("single_den",   32'(den_out),   32'h1);
    chk("single_daddr", 32'(daddr_out), 32'h16);
    tick(); tick(); tick();
    drdy_in = 1'b1; do_in = 16'hABC0;
    tick();
    drdy_in = 1'b0;
    chk("single_valid_a",  32'(valid_a),  32'h1);
    chk("single_sample_a", 32'(sample_a), 32'hABC);
    chk("single_sample_b", 32'(sample_b), 32'h0);
    tick();
    chk("single_valid_end", 32'(valid_a), 32'h0);
    tick();

    // Foreign channel is ignored.
    channel_in = 5'h03; eoc_in = 1'b1;
    tick();
    eoc_in = 1'b0;
    chk("foreign_den", 32'(den_out), 32'h0);
    tick();
    chk("foreign_den2", 32'(den_out), 32'h0);

    // Pending overwrite: two eocs during the A read, only the last survives.
    channel_in = 5'h16; eoc_in = 1'b1;
    tick();
    tick();
    channel_in = 5'h1E;
    tick();
    eoc_in = 1'b0; drdy_in = 1'b1; do_in = 16'h1230;
    tick();
    chk("pend_valid_a", 32'(valid_a), 32'h1);
    do_in = 16'h4560;
    nden = 0; nvb = 0; den_addr = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (den_out === 1'b1) begin nden++; den_addr = daddr_out; end
      if (valid_b === 1'b1) nvb++;
    end
    drdy_in = 1'b0;
    chk("pend_den_count", 32'(nden), 32'd1);
    chk("pend_den_addr",  32'(den_addr), 32'h1E);
    chk("pend_valid_b",   32'(nvb), 32'd1);
    chk("pend_sample_b",  32'(sample_b), 32'h456);

    // Timeout: no drdy at all.
    channel_in = 5'h16; eoc_in = 1'b1;
    tick();
    eoc_in = 1'b0;
    chk("tmo_den", 32'(den_out), 32'h1);
    k = 0;
    do begin
      tick();
      k++;
    end while (err_timeout !== 1'b1 && k < 100);
    chk("tmo_latency", 32'(k), 32'd64);
    chk("tmo_sample_a", 32'(sample_a), 32'h123);
    tick();
    channel_in = 5'h1E; eoc_in = 1'b1;
    tick();
    eoc_in = 1'b0;
    chk("tmo_next_den",   32'(den_out),   32'h1);
    chk("tmo_next_daddr", 32'(daddr_out), 32'h1E);
    tick();
    drdy_in = 1'b1; do_in = 16'h1000;
    tick();
    drdy_in = 1'b0;
    chk("tmo_next_sample", 32'(sample_b), 32'h100);
    tick();

    // Hysteresis on channel B.
    hv = '{12'd3800, 12'd3900, 12'd3801, 12'd3700,
           12'd3800, 12'd3800, 12'd3800, 12'd3800,
           12'd3400, 12'd3400, 12'd3400, 12'd3600,
           12'd3500, 12'd3500, 12'd3500, 12'd3500};
    exp_oc = 16'h7F80;
    for (int i = 0; i < 16; i++) begin
      read_b(hv[i], oc);
      chk($sformatf("hyst_oc_b[%0d]", i), 32'(oc), 32'(exp_oc[i]));
    end

    // Reset while waiting for drdy, then a stray drdy.
    channel_in = 5'h16; eoc_in = 1'b1;
    tick();
    eoc_in = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; drdy_in = 1'b1; do_in = 16'hFFF0;
    tick();
    drdy_in = 1'b0;
    tick();
    chk("rst_sample_a", 32'(sample_a),  32'h0);
    chk("rst_sample_b", 32'(sample_b),  32'h0);
    chk("rst_valid_a",  32'(valid_a),   32'h0);
    chk("rst_den",      32'(den_out),   32'h0);
    chk("rst_daddr",    32'(daddr_out), 32'h16);
    chk("rst_oc_b",     32'(oc_b),      32'h0);

    // Random traffic; drdy density varies so timeouts also occur.
    drdy_div = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) drdy_div = (drdy_div == 3) ? 40 : 3;
      rst_n  = ($urandom_range(0, 599) != 0);
      eoc_in = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: channel_in = 5'h16;
        1: channel_in = 5'h1E;
        2: channel_in = 5'h03;
        default: channel_in = 5'($urandom_range(0, 31));
      endcase
      drdy_in = ($urandom_range(0, drdy_div - 1) == 0);
      if ($urandom_range(0, 1) == 0)
        do_in = {12'($urandom_range(3400, 3900)), 4'($urandom_range(0, 15))};
      else
        do_in = 16'($urandom_range(0, 65535));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_xadc_drp_scheduler
`default_nettype wire
